// File: rtl/seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_ctrl_if
//  Description : Instruction- and data-memory handshake bundle between the
//                methane sequencer (master) and the memory system (slave).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    imem_req   master->slave  fetch request, held until imem_valid
//    imem_addr  master->slave  fetch address
//    imem_valid slave->master  instruction word valid this cycle
//    imem_data  slave->master  instruction word
//    dmem_req   master->slave  data request, held until dmem_done
//    dmem_we    master->slave  1 = store, 0 = load
//    dmem_done  slave->master  data access complete
// ============================================================================
interface seq_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_done;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_valid, imem_data, dmem_done
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_valid, imem_data, dmem_done
    );
endinterface
`default_nettype wire

// File: rtl/seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_ctrl
//  Description : Multi-cycle instruction sequencer for the methane core.
//                Owns the PC and walks each instruction through
//                FETCH -> DECODE -> EXEC -> [MEM] -> WRITE.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rstn        core clock, asynchronous active-low reset
//    start            leave WAIT and begin fetching
//    mem              instruction/data memory handshake (seq_ctrl_if.master)
//    ir, dec_en       latched instruction and one-cycle decode strobe
//    is_*             registered decoder class flags, sampled in EXEC
//    imm, src1        immediate and rs1 value for target computation
//    br_taken         ALU compare result, sampled in EXEC
//    alu_en, rd_we    one-cycle ALU strobe and register write enable
//    pc, instret      current PC and retired-instruction counter
//    halted           sequencer parked in HALT
//    ds_status        sticky [0] illegal, [1] misaligned, [2] mem timeout
// ============================================================================
module seq_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    seq_ctrl_if.master  mem,
    output logic [31:0] ir,
    output logic        dec_en,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        is_illegal,
    input  logic [31:0] imm,
    input  logic [31:0] src1,
    input  logic        br_taken,
    output logic        alu_en,
    output logic        rd_we,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic [2:0]  ds_status
);

    localparam logic [2:0] c_ST_WAIT   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WRITE  = 3'd5;
    localparam logic [2:0] c_ST_HALT   = 3'd6;

    // Last wait cycle index: a request that has gone MEM_TIMEOUT cycles
    // unanswered faults on the edge that ends that cycle.
    localparam logic [7:0] c_TMO_LAST  = 8'(MEM_TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_next_pc;
    logic [31:0] r_instret;
    logic [2:0]  r_status;
    logic [7:0]  r_tmo;
    logic        r_is_store;
    logic        r_no_wb;       // store or branch: no register write-back

    logic [31:0] w_target;

    // Next-PC candidate from the decoder flags presented in EXEC.
    always_comb begin
        w_target = r_pc + 32'd4;
        if (is_jalr) begin
            w_target = (src1 + imm) & ~32'd1;
        end else if (is_jal || (is_branch && br_taken)) begin
            w_target = r_pc + imm;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_ST_WAIT;
            r_pc       <= RESET_PC;
            r_ir       <= 32'd0;
            r_next_pc  <= RESET_PC;
            r_instret  <= 32'd0;
            r_status   <= 3'b000;
            r_tmo      <= 8'd0;
            r_is_store <= 1'b0;
            r_no_wb    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_WAIT: begin
                    if (start) begin
                        r_tmo   <= 8'd0;
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    // valid wins over an expiring timeout
                    if (mem.imem_valid) begin
                        r_ir    <= mem.imem_data;
                        r_state <= c_ST_DECODE;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_status[2] <= 1'b1;
                        r_state     <= c_ST_HALT;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                c_ST_DECODE: begin
                    r_state <= c_ST_EXEC;
                end
                c_ST_EXEC: begin
                    if (is_illegal) begin
                        r_status[0] <= 1'b1;
                        r_state     <= c_ST_HALT;
                    end else if (w_target[1:0] != 2'b00) begin
                        r_status[1] <= 1'b1;
                        r_state     <= c_ST_HALT;
                    end else begin
                        // decoder flags are only valid here, keep what
                        // MEM and WRITE still need
                        r_next_pc  <= w_target;
                        r_is_store <= is_store;
                        r_no_wb    <= is_store | is_branch;
                        r_tmo      <= 8'd0;
                        r_state    <= (is_load || is_store) ? c_ST_MEM : c_ST_WRITE;
                    end
                end
                c_ST_MEM: begin
                    if (mem.dmem_done) begin
                        r_state <= c_ST_WRITE;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_status[2] <= 1'b1;
                        r_state     <= c_ST_HALT;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                c_ST_WRITE: begin
                    r_pc      <= r_next_pc;
                    r_instret <= r_instret + 32'd1;
                    r_tmo     <= 8'd0;
                    r_state   <= c_ST_FETCH;
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_status[2] <= 1'b1;
                    r_state     <= c_ST_HALT;
                end
            endcase
        end
    end

    // Strobes decode straight from state so reset drops them immediately.
    assign mem.imem_req  = (r_state == c_ST_FETCH);
    assign mem.imem_addr = r_pc;
    assign mem.dmem_req  = (r_state == c_ST_MEM);
    assign mem.dmem_we   = (r_state == c_ST_MEM) && r_is_store;
    assign dec_en        = (r_state == c_ST_DECODE);
    assign alu_en        = (r_state == c_ST_EXEC);
    assign rd_we         = (r_state == c_ST_WRITE) && !r_no_wb;
    assign halted        = (r_state == c_ST_HALT);
    assign ir            = r_ir;
    assign pc            = r_pc;
    assign instret       = r_instret;
    assign ds_status     = r_status;

endmodule
`default_nettype wire
